// File: rtl/ram_access_frontend_if.sv
// Command/response bus between a requester (master) and ram_access_frontend (slave).
// Carries byte-addressed read/write commands and the registered read response.
interface ram_access_frontend_if #(
  parameter int DATA_WIDTH      = 64,
  parameter int BYTE_ADDR_WIDTH = 16
);
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [BYTE_ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0]      cmd_wdata;
  logic [DATA_WIDTH/8-1:0]    cmd_wstrb;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;
  logic                       rsp_write;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_write
  );
endinterface

// File: rtl/ram_access_frontend.sv
// Serialises byte-addressed read/write commands onto a single-port RAM and returns read responses.
// Define RAM_FRONTEND_WRITE_ACK_EN to make writes produce a response as well.
module ram_access_frontend #(
  parameter int DATA_WIDTH      = 64,
  parameter int MEM_DEPTH       = 256,
  parameter int ADDR_WIDTH      = $clog2(MEM_DEPTH),
  parameter int BYTE_ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ram_access_frontend_if.slave    bus,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_read_enable,
  input  logic [DATA_WIDTH-1:0]   ram_read_data,
  output logic [DATA_WIDTH-1:0]   ram_write_data,
  output logic [DATA_WIDTH/8-1:0] ram_write_enable
);
  localparam int OFFSET_BITS = $clog2(DATA_WIDTH / 8);
  localparam logic [BYTE_ADDR_WIDTH-1:0] DEPTH_LIMIT = BYTE_ADDR_WIDTH'(MEM_DEPTH);

  logic [BYTE_ADDR_WIDTH-1:0] word_idx;
  logic                       in_range;
  logic                       slot_free;
  logic                       ready_raw;
  logic                       accept;
  logic                       rsp_fire;
  logic                       rsp_valid_q;
  logic                       rsp_err_q;
  logic                       data_sel_q;
`ifdef RAM_FRONTEND_WRITE_ACK_EN
  logic                       rsp_write_q;
`endif

  assign word_idx  = bus.cmd_addr >> OFFSET_BITS;
  assign in_range  = word_idx < DEPTH_LIMIT;
  assign slot_free = !rsp_valid_q || bus.rsp_ready;

  // Writes leave the held RAM read data alone, so only the ACK build makes them wait on the response slot.
`ifdef RAM_FRONTEND_WRITE_ACK_EN
  assign ready_raw = slot_free;
  assign rsp_fire  = accept;
`else
  assign ready_raw = bus.cmd_write || slot_free;
  assign rsp_fire  = accept && !bus.cmd_write;
`endif

  assign bus.cmd_ready = rst_n && ready_raw;
  assign accept        = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    ram_addr         = word_idx[ADDR_WIDTH-1:0];
    ram_write_data   = bus.cmd_wdata;
    ram_read_enable  = 1'b0;
    ram_write_enable = '0;
    if (accept && in_range) begin
      if (bus.cmd_write) begin
        ram_write_enable = bus.cmd_wstrb;
      end else begin
        ram_read_enable = 1'b1;
      end
    end
  end

  // data_sel_q picks the RAM output only for in-range reads; errors and write acks return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      data_sel_q  <= 1'b0;
`ifdef RAM_FRONTEND_WRITE_ACK_EN
      rsp_write_q <= 1'b0;
`endif
    end else if (rsp_fire) begin
      rsp_valid_q <= 1'b1;
      rsp_err_q   <= !in_range;
      data_sel_q  <= in_range && !bus.cmd_write;
`ifdef RAM_FRONTEND_WRITE_ACK_EN
      rsp_write_q <= bus.cmd_write;
`endif
    end else if (bus.rsp_ready) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      data_sel_q  <= 1'b0;
`ifdef RAM_FRONTEND_WRITE_ACK_EN
      rsp_write_q <= 1'b0;
`endif
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = data_sel_q ? ram_read_data : '0;
`ifdef RAM_FRONTEND_WRITE_ACK_EN
  assign bus.rsp_write = rsp_write_q;
`else
  assign bus.rsp_write = 1'b0;
`endif

endmodule

// File: tb/tb_ram_access_frontend.sv
// Scoreboard bench for ram_access_frontend: directed scenarios plus random traffic against a
// word-array reference model; a behavioural single-port RAM sits behind the DUT.
module tb_ram_access_frontend;
  localparam int DW    = 64;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int BAW   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram_access_frontend_if #(.DATA_WIDTH(DW), .BYTE_ADDR_WIDTH(BAW)) bus ();

  logic [AW-1:0]   ram_addr;
  logic            ram_read_enable;
  logic [DW-1:0]   ram_read_data;
  logic [DW-1:0]   ram_write_data;
  logic [DW/8-1:0] ram_write_enable;

  ram_access_frontend #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .BYTE_ADDR_WIDTH(BAW)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus              (bus),
    .ram_addr         (ram_addr),
    .ram_read_enable  (ram_read_enable),
    .ram_read_data    (ram_read_data),
    .ram_write_data   (ram_write_data),
    .ram_write_enable (ram_write_enable)
  );

  // Behavioural single-port RAM: byte enables, 1-cycle read latency, output holds when idle.
  logic [DW-1:0] ram_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    ram_read_data = '0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < DW/8; b++)
      if (ram_write_enable[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_write_data[b*8 +: 8];
    if (ram_read_enable) ram_read_data <= ram_mem[ram_addr];
  end

`ifdef RAM_FRONTEND_WRITE_ACK_EN
  localparam bit ACK_BUILD = 1'b1;
`else
  localparam bit ACK_BUILD = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          wr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            compared_count   = 0;
  int            mismatched_count = 0;

  int stall_req    = 0;
  int stall_served = 0;
  int stall_len    = 3;
  bit ready_random = 1'b0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    compared_count++;
    if (actual !== expected) begin
      mismatched_count++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, expected, $time);
    end
  endtask

  // rsp_ready driver: either always-ready, random back-pressure, or a fixed stall after a requested response.
  initial begin
    int stall_left = 0;
    bus.rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_served != stall_req && bus.rsp_valid) begin
        stall_left   = stall_len;
        stall_served = stall_req;
      end
      if (stall_left > 0) begin
        bus.rsp_ready = 1'b0;
        stall_left--;
      end else begin
        bus.rsp_ready = ready_random ? ($urandom_range(3) != 0) : 1'b1;
      end
    end
  end

  // Monitor/scoreboard: sampled at the falling edge, i.e. what the next rising edge will act upon.
  initial begin
    logic [DW-1:0] held_rdata;
    logic          held_err;
    logic          held_wr;
    bit            holding = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        holding = 1'b0;
        checkOutput("reset_cmd_ready", DW'(bus.cmd_ready), '0);
        checkOutput("reset_ram_re", DW'(ram_read_enable), '0);
        checkOutput("reset_ram_we", DW'(ram_write_enable), '0);
      end else begin
        bit model_valid;
        bit exp_ready;
        model_valid = exp_q.size() != 0;
        checkOutput("rsp_valid", DW'(bus.rsp_valid), DW'(model_valid));
        if (holding) begin
          checkOutput("stall_rsp_rdata", bus.rsp_rdata, held_rdata);
          checkOutput("stall_rsp_err", DW'(bus.rsp_err), DW'(held_err));
          checkOutput("stall_rsp_write", DW'(bus.rsp_write), DW'(held_wr));
        end
        holding    = bus.rsp_valid && !bus.rsp_ready;
        held_rdata = bus.rsp_rdata;
        held_err   = bus.rsp_err;
        held_wr    = bus.rsp_write;

        if (bus.rsp_valid && bus.rsp_ready) begin
          if (exp_q.size() == 0) begin
            checkOutput("rsp_unexpected", DW'(bus.rsp_valid), '0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput("rsp_rdata", bus.rsp_rdata, e.rdata);
            checkOutput("rsp_err", DW'(bus.rsp_err), DW'(e.err));
            checkOutput("rsp_write", DW'(bus.rsp_write), DW'(e.wr));
          end
        end

        exp_ready = (!ACK_BUILD && bus.cmd_write) || !model_valid || bus.rsp_ready;
        if (bus.cmd_valid) checkOutput("cmd_ready", DW'(bus.cmd_ready), DW'(exp_ready));

        if (bus.cmd_valid && bus.cmd_ready) begin
          int unsigned word;
          bit          inr;
          exp_t        e;
          word = int'(bus.cmd_addr) / (DW/8);
          inr  = word < DEPTH;
          checkOutput("ram_re", DW'(ram_read_enable), DW'(inr && !bus.cmd_write));
          checkOutput("ram_we", DW'(ram_write_enable), (inr && bus.cmd_write) ? DW'(bus.cmd_wstrb) : '0);
          if (inr) checkOutput("ram_addr", DW'(ram_addr), DW'(word % DEPTH));
          if (inr && bus.cmd_write) begin
            checkOutput("ram_wdata", ram_write_data, bus.cmd_wdata);
            for (int b = 0; b < DW/8; b++)
              if (bus.cmd_wstrb[b]) model_mem[word][b*8 +: 8] = bus.cmd_wdata[b*8 +: 8];
          end
          if (!bus.cmd_write) begin
            e.rdata = inr ? model_mem[word] : '0;
            e.err   = !inr;
            e.wr    = 1'b0;
            exp_q.push_back(e);
          end else if (ACK_BUILD) begin
            e.rdata = '0;
            e.err   = !inr;
            e.wr    = 1'b1;
            exp_q.push_back(e);
          end
        end else begin
          checkOutput("idle_ram_re", DW'(ram_read_enable), '0);
          checkOutput("idle_ram_we", DW'(ram_write_enable), '0);
        end
      end
    end
  end

  // Presents one command and holds it until accepted, bounded so a stuck cmd_ready cannot hang the run.
  task automatic applyStimulus(input logic wr, input logic [BAW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [DW/8-1:0] wstrb);
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    bus.cmd_wstrb = wstrb;
    bus.cmd_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (bus.cmd_ready) begin
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        return;
      end
    end
    checkOutput("cmd_accept_timeout", DW'(bus.cmd_ready), DW'(1));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.cmd_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_rsp_valid", DW'(bus.rsp_valid), '0);
    checkOutput("post_reset_rsp_err", DW'(bus.rsp_err), '0);
    checkOutput("post_reset_rsp_write", DW'(bus.rsp_write), '0);
    @(posedge clk);
    #1;

    $display("[TB] full and partial write, read back");
    applyStimulus(1'b1, 16'h0010, 64'h1122334455667788, 8'hFF);
    applyStimulus(1'b0, 16'h0010, '0, '0);
    applyStimulus(1'b1, 16'h0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
    applyStimulus(1'b0, 16'h0014, '0, '0);
    applyStimulus(1'b1, 16'h0020, 64'hDEADBEEFDEADBEEF, 8'h00);
    applyStimulus(1'b0, 16'h0020, '0, '0);

    $display("[TB] out-of-range read and write");
    applyStimulus(1'b0, 16'h0800, '0, '0);
    applyStimulus(1'b1, 16'h0800, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
    applyStimulus(1'b0, 16'h07F8, '0, '0);

    $display("[TB] back-to-back reads with a 3-cycle stall");
    stall_len = 3;
    stall_req++;
    applyStimulus(1'b0, 16'h0000, '0, '0);
    applyStimulus(1'b0, 16'h0008, '0, '0);
    applyStimulus(1'b0, 16'h0010, '0, '0);

    $display("[TB] write issued during a stalled read response");
    stall_len = 4;
    stall_req++;
    applyStimulus(1'b0, 16'h0010, '0, '0);
    applyStimulus(1'b1, 16'h0018, 64'h0123456789ABCDEF, 8'hFF);
    applyStimulus(1'b0, 16'h0018, '0, '0);

    $display("[TB] reset while a response is pending");
    stall_len = 6;
    stall_req++;
    applyStimulus(1'b0, 16'h0010, '0, '0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_drop_rsp_valid", DW'(bus.rsp_valid), '0);
    @(posedge clk);
    #1;
    repeat (6) begin @(posedge clk); #1; end
    applyStimulus(1'b0, 16'h0010, '0, '0);
    applyStimulus(1'b0, 16'h0018, '0, '0);

    $display("[TB] random traffic");
    ready_random = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [BAW-1:0] a;
      a = ($urandom_range(7) == 0) ? BAW'($urandom) : BAW'($urandom_range(16'h07FF));
      applyStimulus(1'($urandom_range(1)), a, {$urandom, $urandom}, 8'($urandom));
      repeat ($urandom_range(2)) begin @(posedge clk); #1; end
    end

    ready_random = 1'b0;
    for (int t = 0; t < 50 && (exp_q.size() != 0 || bus.rsp_valid); t++) @(negedge clk);
    checkOutput("drain_pending", DW'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_count, mismatched_count);
    $finish;
  end

endmodule

// File: doc/ram_access_frontend.md
Name: ram_access_frontend

Overview:
Request/response front end that sits directly upstream of the single-port RAM and drives its shared-address port. It accepts byte-addressed read/write commands over a valid/ready handshake and serialises them onto the one RAM port, at most one access per cycle. It returns read data, with a response handshake that tolerates back-pressure. It also range-checks addresses, so out-of-range commands never reach the RAM.

Parameters:
DATA_WIDTH, 64, data width in bits; multiple of 8
MEM_DEPTH, 256, RAM depth in words
ADDR_WIDTH, $clog2(MEM_DEPTH), RAM word-address width
BYTE_ADDR_WIDTH, 16, command byte-address width; must be >= ADDR_WIDTH + $clog2(DATA_WIDTH/8)

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
cmd_valid  in  1  command valid
cmd_ready  out  1  command ready
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  BYTE_ADDR_WIDTH  byte address
cmd_wdata  in  DATA_WIDTH  write data
cmd_wstrb  in  DATA_WIDTH/8  byte strobes for writes
rsp_valid  out  1  response valid
rsp_ready  in  1  response ready
rsp_rdata  out  DATA_WIDTH  read data; 0 on error or write response
rsp_err  out  1  address out of range
rsp_write  out  1  response belongs to a write (ACK build only; otherwise tied 0)
ram_addr  out  ADDR_WIDTH  to RAM addr
ram_read_enable  out  1  to RAM read_enable
ram_read_data  in  DATA_WIDTH  from RAM read_data (1-cycle latency, holds when read_enable low)
ram_write_data  out  DATA_WIDTH  to RAM write_data
ram_write_enable  out  DATA_WIDTH/8  to RAM byte write enables

Behaviour:
- Interface contract: one clock (clk); reset rst_n is synchronous and active-low.
- Reset: rsp_valid=0, rsp_err=0, rsp_write=0, internal err/data-select flags=0. While rst_n=0: cmd_ready=0, ram_read_enable=0, ram_write_enable=0.
- Accept: a command is accepted when cmd_valid && cmd_ready at a rising edge.
- Address decode: word index = cmd_addr >> $clog2(DATA_WIDTH/8); low byte-offset bits are ignored. In range iff word index < MEM_DEPTH. ram_addr = word index truncated to ADDR_WIDTH.
- RAM drive is combinational from the command in the accept cycle:
  - In-range read: ram_read_enable=1.
  - In-range write: ram_write_enable=cmd_wstrb, ram_write_data=cmd_wdata.
  - All enables are 0 when no command is accepted or the command is out of range.
- Reads: cmd_ready = !rsp_valid || rsp_ready. On accept, rsp_valid=1 next cycle and rsp_err = out-of-range. rsp_rdata = rsp_err ? 0 : ram_read_data. Latency is 1 cycle; read throughput is 1 per cycle while rsp_ready=1.
- Back-pressure: while rsp_valid && !rsp_ready, ram_read_enable stays 0, so the RAM holds read_data and rsp_rdata is stable. rsp_valid, rsp_err and rsp_rdata must not change until the handshake completes.
- Response retire: rsp_valid clears on rsp_ready unless a new response is accepted in the same cycle (back-to-back allowed).
- Writes (base build): complete silently and produce no response. A write is accepted even while a read response is stalled (cmd_ready=1 for writes), because write enables do not disturb held read_data. Out-of-range writes are dropped silently.
- Write strobes: wstrb=0 is accepted as a no-op write.
- Ordering: read after write to the same address in consecutive cycles returns the new data (the write commits at the edge before the read edge).
- Reset mid-operation: a pending response is discarded, the next response after reset comes only from a post-reset command, and RAM contents are untouched.

Optional Feature:
RAM_FRONTEND_WRITE_ACK_EN
- Defined: every write also produces a response: rsp_valid=1 next cycle, rsp_write=1, rsp_rdata=0, rsp_err=out-of-range. Writes then obey the same cmd_ready = !rsp_valid || rsp_ready rule as reads.
- Undefined: the base behaviour above applies, and rsp_write is constant 0.

Test Plan:
- Write addr 0x0010 data 0x1122334455667788 wstrb 0xFF, then read 0x0010 -> rsp_valid 1 cycle after read accept, rsp_rdata 0x1122334455667788, rsp_err 0.
- Partial write wstrb 0x0F data 0xAAAAAAAAAAAAAAAA to 0x0010, then read -> rsp_rdata 0x11223344AAAAAAAA.
- Read 0x0800 (word 256, out of range) -> rsp_err 1, rsp_rdata 0, ram_read_enable never asserted; write 0x0800 -> ram_write_enable stays 0.
- Back-to-back reads 0x0000, 0x0008, 0x0010 with rsp_ready held 0 for 3 cycles after the first response -> cmd_ready 0 and rsp_rdata stable during stall; three responses delivered in order after release, no loss.
- Write to 0x0018 issued while a read response is stalled -> base build: cmd_ready 1 and write committed; ACK build: cmd_ready 0 until the response retires, then write accepted and response with rsp_write 1.
- rst_n low for 1 cycle while rsp_valid 1 -> rsp_valid 0 next cycle, cmd_ready 0 during reset, previously written data still readable afterwards.
